// File: rtl/key_pulse_gen.sv
// Purpose  : debounces raw push buttons into one-cycle press pulses plus a clean held level.
// Latency  : key_press/key_level rise DEBOUNCE_CYCLES+2 edges after the first edge sampling key_raw=1.
// Backpress: none; the consumer samples key_press every clk, no handshake.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset (flops, FSMs, counters, outputs)
//   key_raw    raw active-high buttons, asynchronous to clk (bit0 BTNU, bit1 BTND, bit2 BTNC)
//   key_press  registered one-cycle pulse per accepted press
//   key_level  registered debounced level, 1 = held
//
// Optional feature macro: KEY_AUTOREPEAT_EN
//   defined   -> a held key repeats its pulse after REPEAT_DELAY, then every REPEAT_PERIOD cycles
//   undefined -> exactly one pulse per press, repeat logic absent
module key_pulse_gen #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_level
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEB_DN = 2'd1,
    HELD   = 2'd2,
    DEB_UP = 2'd3
  } state_t;

  // Two-flop synchroniser for every key; r_sync2 is the only value the FSMs look at.
  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifndef KEY_AUTOREPEAT_EN
  // Repeat parameters have no effect in the single-pulse build.
  logic w_unused_rpt;
  assign w_unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_level;
    logic             w_sync;

    assign w_sync       = r_sync2[i];
    assign key_press[i] = r_press;
    assign key_level[i] = r_level;

`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic [RPT_W-1:0] r_rpt_cnt;
    logic             r_rpt_first_done;  // first repeat already issued -> use REPEAT_PERIOD
    logic [RPT_W-1:0] w_rpt_last;

    assign w_rpt_last = r_rpt_first_done ? RPT_W'(REPEAT_PERIOD - 1)
                                         : RPT_W'(REPEAT_DELAY - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_press <= 1'b0;
        r_level <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        r_rpt_cnt        <= '0;
        r_rpt_first_done <= 1'b0;
`endif
      end else begin
        r_press <= 1'b0;
        case (r_state)
          IDLE: begin
            if (w_sync) begin
              r_state <= DEB_DN;
              r_cnt   <= '0;
            end
          end

          DEB_DN: begin
            if (!w_sync) begin
              r_state <= IDLE;  // bounce: silently abandon
            end else if (r_cnt == CNT_LAST) begin
              // cnt holds at its last value through the state change, never wraps
              r_state <= HELD;
              r_press <= 1'b1;
              r_level <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
              r_rpt_cnt        <= '0;
              r_rpt_first_done <= 1'b0;
`endif
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          HELD: begin
            if (!w_sync) begin
              r_state <= DEB_UP;
              r_cnt   <= '0;
`ifdef KEY_AUTOREPEAT_EN
              r_rpt_cnt        <= '0;
              r_rpt_first_done <= 1'b0;
            end else if (r_rpt_cnt == w_rpt_last) begin
              r_press          <= 1'b1;
              r_rpt_cnt        <= '0;
              r_rpt_first_done <= 1'b1;
            end else begin
              r_rpt_cnt <= r_rpt_cnt + 1'b1;
`endif
            end
          end

          DEB_UP: begin
            if (w_sync) begin
              // release bounce: back to held without a pulse; repeat delay starts over
              r_state <= HELD;
`ifdef KEY_AUTOREPEAT_EN
              r_rpt_cnt        <= '0;
              r_rpt_first_done <= 1'b0;
`endif
            end else if (r_cnt == CNT_LAST) begin
              r_state <= IDLE;
              r_level <= 1'b0;  // release never pulses
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Purpose  : directed self-checking bench for key_pulse_gen with short debounce/repeat constants.
// Latency  : expects outputs on edge k+10 for DEBOUNCE_CYCLES=8 (k = first edge sampling the key).
// Backpress: not applicable; outputs sampled 1 time unit after each rising edge.
module tb_key_pulse_gen;

  localparam int NK = 3;
  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RP = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_raw = '0;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_level;

  int n_checks = 0;
  int n_errors = 0;

  key_pulse_gen #(
    .N_KEYS          (NK),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw   (key_raw),
    .key_press (key_press),
    .key_level (key_level)
  );

  always #5 clk = ~clk;

  // Pulse counters and back-to-back pulse detector, sampled on the falling edge.
  int unsigned   pulse_cnt [NK] = '{0, 0, 0};
  int unsigned   dbl_cnt = 0;
  logic [NK-1:0] prev_press = '0;

  always @(negedge clk) begin
    for (int i = 0; i < NK; i++) begin
      if (key_press[i]) pulse_cnt[i]++;
    end
    if (|(key_press & prev_press)) dbl_cnt++;
    prev_press = key_press;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic ticks(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int unsigned base0;
  int unsigned base1;
  int unsigned base2;
  logic [31:0] exp_rep;

  initial begin
    // ---------------- reset state ----------------
    ticks(3);
    check("rst_press", key_press, 3'b000);
    check("rst_level", key_level, 3'b000);
    rst_n = 1'b1;
    ticks(3);
    check("idle_press", key_press, 3'b000);

    // ---------------- clean press on key 0 ----------------
    base0 = pulse_cnt[0];
    key_raw = 3'b001;          // edge k is the next edge
    ticks(10);                 // after edge k+9
    check("clean_pre_press", key_press, 3'b000);
    check("clean_pre_level", key_level, 3'b000);
    ticks(1);                  // after edge k+10
    check("clean_press", key_press, 3'b001);
    check("clean_level", key_level, 3'b001);
    ticks(1);
    check("clean_press_off", key_press, 3'b000);
    check("clean_level_hold", key_level, 3'b001);
    ticks(18);                 // held 30 cycles in total
    check("clean_one_pulse", pulse_cnt[0] - base0, 1);
    key_raw = 3'b000;          // release edge r is the next edge
    ticks(10);
    check("rel_level_pre", key_level, 3'b001);
    ticks(1);                  // after edge r+10
    check("rel_level", key_level, 3'b000);
    check("rel_press", key_press, 3'b000);
    ticks(5);
    check("rel_no_pulse", pulse_cnt[0] - base0, 1);

    // ---------------- bounce on key 2 ----------------
    base2 = pulse_cnt[2];
    for (int b = 0; b < 10; b++) begin
      key_raw[2] = ~key_raw[2];
      ticks(3);
    end
    check("bounce_no_pulse", pulse_cnt[2] - base2, 0);
    check("bounce_level", key_level, 3'b000);
    key_raw[2] = 1'b1;         // edge s is the next edge
    ticks(10);
    check("bounce_pre_press", key_press, 3'b000);
    ticks(1);                  // after edge s+10
    check("bounce_press", key_press, 3'b100);
    check("bounce_level_hi", key_level, 3'b100);
    ticks(3);
    check("bounce_one_pulse", pulse_cnt[2] - base2, 1);
    key_raw[2] = 1'b0;
    ticks(12);
    check("bounce_rel_level", key_level, 3'b000);

    // ---------------- glitch on key 1 ----------------
    base1 = pulse_cnt[1];
    key_raw[1] = 1'b1;
    ticks(5);
    key_raw[1] = 1'b0;
    ticks(15);
    check("glitch_pulses", pulse_cnt[1] - base1, 0);
    check("glitch_level", key_level, 3'b000);

    // ---------------- simultaneous keys 0 and 1 ----------------
    key_raw = 3'b011;
    ticks(10);
    check("simul_pre", key_press, 3'b000);
    ticks(1);
    check("simul_press", key_press, 3'b011);
    check("simul_level", key_level, 3'b011);
    ticks(1);
    check("simul_press_off", key_press, 3'b000);
    key_raw = 3'b000;
    ticks(12);
    check("simul_rel_level", key_level, 3'b000);

    // ---------------- reset while debouncing (DEB_DN, cnt=5) ----------------
    base0 = pulse_cnt[0];
    key_raw = 3'b001;          // edge k next; DEB_DN cnt=5 after edge k+7
    ticks(8);
    rst_n = 1'b0;
    #1;
    check("rstdn_press", key_press, 3'b000);
    check("rstdn_level", key_level, 3'b000);
    ticks(3);
    rst_n = 1'b1;              // first sampling edge j is the next edge
    ticks(10);
    check("rstdn_pre_press", key_press, 3'b000);
    ticks(1);                  // after edge j+10
    check("rstdn_press_j10", key_press, 3'b001);
    check("rstdn_level_j10", key_level, 3'b001);
    ticks(3);
    check("rstdn_one_pulse", pulse_cnt[0] - base0, 1);

    // ---------------- reset while held: outputs drop at once ----------------
    rst_n = 1'b0;
    #1;
    check("rsthold_level", key_level, 3'b000);
    key_raw = 3'b000;
    ticks(2);
    rst_n = 1'b1;
    ticks(4);

    // ---------------- long hold: auto-repeat or single pulse ----------------
    base0 = pulse_cnt[0];
    key_raw = 3'b001;
    ticks(11);                 // after edge P
    check("rep_first", key_press, 3'b001);
    for (int m = 1; m <= 40; m++) begin
      ticks(1);
`ifdef KEY_AUTOREPEAT_EN
      exp_rep = (m == 20 || m == 26 || m == 32 || m == 38) ? 32'd1 : 32'd0;
`else
      exp_rep = 32'd0;
`endif
      check($sformatf("rep_P+%0d", m), {31'd0, key_press[0]}, exp_rep);
    end
    key_raw = 3'b000;
    ticks(14);
`ifdef KEY_AUTOREPEAT_EN
    check("rep_total", pulse_cnt[0] - base0, 5);
`else
    check("rep_total", pulse_cnt[0] - base0, 1);
`endif
    check("rep_rel_level", key_level, 3'b000);

    check("no_back_to_back", dbl_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
